// File: rtl/vga_axil_master_fsm_if.sv
// AXI-Lite bus bundle between the command-driven master and an AXI-Lite slave.
// Signal names keep the master's point of view (_o driven by master, _i driven by slave).
interface vga_axil_master_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr_o;
    logic [2:0]          awprot_o;
    logic                awvalid_o;
    logic                awready_i;
    logic [DATA_W-1:0]   wdata_o;
    logic [DATA_W/8-1:0] wstrb_o;
    logic                wvalid_o;
    logic                wready_i;
    logic [1:0]          bresp_i;
    logic                bvalid_i;
    logic                bready_o;
    logic [ADDR_W-1:0]   araddr_o;
    logic [2:0]          arprot_o;
    logic                arvalid_o;
    logic                arready_i;
    logic [DATA_W-1:0]   rdata_i;
    logic [1:0]          rresp_i;
    logic                rvalid_i;
    logic                rready_o;

    modport master (
        output awaddr_o, awprot_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
               araddr_o, arprot_o, arvalid_o, rready_o,
        input  awready_i, wready_i, bresp_i, bvalid_i, arready_i, rdata_i, rresp_i, rvalid_i
    );

    modport slave (
        input  awaddr_o, awprot_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
               araddr_o, arprot_o, arvalid_o, rready_o,
        output awready_i, wready_i, bresp_i, bvalid_i, arready_i, rdata_i, rresp_i, rvalid_i
    );
endinterface

// File: rtl/vga_axil_master_fsm.sv
// Single-outstanding AXI-Lite master: turns native read/write commands into AW/W/B or AR/R
// transfers and reports completion with a one-cycle response pulse.
module vga_axil_master_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    vga_axil_master_fsm_if.master axi
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWrAddrData = 3'd1,
        StWrResp     = 3'd2,
        StRdAddr     = 3'd3,
        StRdData     = 3'd4
    } state_t;

    state_t r_state;
    logic   r_aw_done;
    logic   r_w_done;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_all;
    logic w_w_all;

    assign w_cmd_hs = cmd_valid_i && cmd_ready_o;
    assign w_aw_hs  = axi.awvalid_o && axi.awready_i;
    assign w_w_hs   = axi.wvalid_o && axi.wready_i;
    assign w_b_hs   = axi.bvalid_i && axi.bready_o;
    assign w_ar_hs  = axi.arvalid_o && axi.arready_i;
    assign w_r_hs   = axi.rvalid_i && axi.rready_o;
    // AW and W may finish in either order or together; each side counts once.
    assign w_aw_all = r_aw_done || w_aw_hs;
    assign w_w_all  = r_w_done || w_w_hs;

    assign axi.awprot_o = 3'b000;
    assign axi.arprot_o = 3'b000;

    // NOTE: every output below is a flop updated with non-blocking assignments, so no slave
    // input ever reaches an output combinationally and all regs see the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= '0;
            axi.awaddr_o  <= '0;
            axi.awvalid_o <= 1'b0;
            axi.wdata_o   <= '0;
            axi.wstrb_o   <= '0;
            axi.wvalid_o  <= 1'b0;
            axi.bready_o  <= 1'b0;
            axi.araddr_o  <= '0;
            axi.arvalid_o <= 1'b0;
            axi.rready_o  <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (r_state)
                StIdle: begin
                    cmd_ready_o <= 1'b1;
                    r_aw_done   <= 1'b0;
                    r_w_done    <= 1'b0;
                    if (w_cmd_hs) begin
                        cmd_ready_o <= 1'b0;
                        if (cmd_we_i) begin
                            r_state       <= StWrAddrData;
                            axi.awaddr_o  <= cmd_addr_i;
                            axi.wdata_o   <= cmd_wdata_i;
                            axi.wstrb_o   <= '1;
                            axi.awvalid_o <= 1'b1;
                            axi.wvalid_o  <= 1'b1;
                        end else begin
                            r_state       <= StRdAddr;
                            axi.araddr_o  <= cmd_addr_i;
                            axi.arvalid_o <= 1'b1;
                        end
                    end
                end
                StWrAddrData: begin
                    if (w_aw_hs) begin
                        axi.awvalid_o <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (w_w_hs) begin
                        axi.wvalid_o <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_state      <= StWrResp;
                        axi.bready_o <= 1'b1;
                    end
                end
                StWrResp: begin
                    if (w_b_hs) begin
                        r_state      <= StIdle;
                        axi.bready_o <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_err_o    <= (axi.bresp_i != 2'b00);
                        cmd_ready_o  <= 1'b1;
                    end
                end
                StRdAddr: begin
                    if (w_ar_hs) begin
                        r_state       <= StRdData;
                        axi.arvalid_o <= 1'b0;
                        axi.rready_o  <= 1'b1;
                    end
                end
                StRdData: begin
                    if (w_r_hs) begin
                        r_state      <= StIdle;
                        axi.rready_o <= 1'b0;
                        rsp_rdata_o  <= axi.rdata_i;
                        rsp_valid_o  <= 1'b1;
                        rsp_err_o    <= (axi.rresp_i != 2'b00);
                        cmd_ready_o  <= 1'b1;
                    end
                end
                // NOTE: an illegal encoding drops every handshake and recovers through idle.
                default: begin
                    r_state       <= StIdle;
                    cmd_ready_o   <= 1'b0;
                    axi.awvalid_o <= 1'b0;
                    axi.wvalid_o  <= 1'b0;
                    axi.bready_o  <= 1'b0;
                    axi.arvalid_o <= 1'b0;
                    axi.rready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// Directed bench for vga_axil_master_fsm: table of single transactions against a delay-programmable
// slave, plus hand-written back-to-back and mid-transaction reset sequences.
module tb_vga_axil_master_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vga_axil_master_fsm_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    vga_axil_master_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .axi         (axi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        axi.awready_i = 1'b0;
        axi.wready_i  = 1'b0;
        axi.bvalid_i  = 1'b0;
        axi.bresp_i   = 2'b00;
        axi.arready_i = 1'b0;
        axi.rvalid_i  = 1'b0;
        axi.rresp_i   = 2'b00;
        axi.rdata_i   = '0;
    endtask

    // One command against a slave whose ready/valid timing comes from the vector.
    task automatic run_vec(input int idx, input vec_t v);
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
        int rsp_cnt = 0, acc_cyc = -1000, rsp_cyc = 1000, tail = -1;
        bit accepted = 0, stable_ok = 1, wr_both, rd_addr_done;
        logic err_seen = 1'bx;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        for (int t = 0; t < 40 && tail != 0; t++) begin
            if (accepted) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc  = cyc;
                err_seen = rsp_err;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            wr_both      = (aw_beats > 0) && (w_beats > 0);
            rd_addr_done = (ar_beats > 0);

            axi.awready_i = axi.awvalid_o && (aw_cnt >= v.aw_dly);
            if (axi.awvalid_o) begin
                if (axi.awaddr_o !== v.addr) stable_ok = 0;
                aw_cnt++;
                if (axi.awready_i) aw_beats++;
            end
            axi.wready_i = axi.wvalid_o && (w_cnt >= v.w_dly);
            if (axi.wvalid_o) begin
                if (axi.wdata_o !== v.wdata || axi.wstrb_o !== 4'hF) stable_ok = 0;
                w_cnt++;
                if (axi.wready_i) w_beats++;
            end
            axi.bvalid_i = 1'b0;
            axi.bresp_i  = v.resp;
            if (wr_both && b_beats == 0) begin
                axi.bvalid_i = (b_cnt >= v.b_dly);
                b_cnt++;
                if (axi.bvalid_i && axi.bready_o) b_beats++;
            end
            axi.arready_i = axi.arvalid_o && (ar_cnt >= v.ar_dly);
            if (axi.arvalid_o) begin
                if (axi.araddr_o !== v.addr) stable_ok = 0;
                ar_cnt++;
                if (axi.arready_i) ar_beats++;
            end
            axi.rvalid_i = 1'b0;
            axi.rdata_i  = v.rdata;
            axi.rresp_i  = v.resp;
            if (rd_addr_done && r_beats == 0) begin
                axi.rvalid_i = (r_cnt >= v.r_dly);
                r_cnt++;
                if (axi.rvalid_i && axi.rready_o) r_beats++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        slave_idle();
        check($sformatf("v%0d_rsp_pulses", idx), rsp_cnt, 1);
        check($sformatf("v%0d_err", idx), err_seen, v.exp_err);
        check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_latency", idx), rsp_cyc - acc_cyc + 1, v.exp_lat);
        check($sformatf("v%0d_beats", idx),
              (aw_beats << 16) | (w_beats << 12) | (b_beats << 8) | (ar_beats << 4) | r_beats,
              v.we ? 20'h11100 : 20'h00011);
        check($sformatf("v%0d_stable", idx), stable_ok, 1);
    endtask

    initial begin
        int n_acc, n_rsp, ar_first;
        int acc_c[2];
        int rsp_c[2];
        bit overlap, addr_ok, acc_flag, saw_rsp;

        //          we    addr        wdata         aw w  b  ar r  resp   rdata         err   exp_rdata     lat
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'h0,        4};
        vecs[1] = '{1'b1, 32'h20, 32'hA5A5A5A5, 3, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'h0,        7};
        vecs[2] = '{1'b1, 32'h30, 32'h01020304, 0, 2, 1, 0, 0, 2'b11, 32'h0,        1'b1, 32'h0,        7};
        vecs[3] = '{1'b0, 32'h24, 32'h0,        0, 0, 0, 2, 0, 2'b00, 32'h12345678, 1'b0, 32'h12345678, 6};
        vecs[4] = '{1'b0, 32'h28, 32'h0,        0, 0, 0, 0, 3, 2'b10, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 7};
        vecs[5] = '{1'b1, 32'h40, 32'h55AA55AA, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'hCAFEF00D, 4};
        vecs[6] = '{1'b1, 32'h44, 32'h0F0F0F0F, 1, 1, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'hCAFEF00D, 5};
        vecs[7] = '{1'b0, 32'h48, 32'h0,        0, 0, 0, 1, 1, 2'b00, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 6};

        slave_idle();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_handshakes", {axi.awvalid_o, axi.wvalid_o, axi.bready_o, axi.arvalid_o,
                                 axi.rready_o, rsp_valid, rsp_err}, 7'b0);
        check("rst_data", {axi.awaddr_o, axi.araddr_o, axi.wdata_o, rsp_rdata} == 128'h0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back write then read with cmd_valid held; ready slave throughout.
        n_acc = 0; n_rsp = 0; overlap = 0; addr_ok = 1; ar_first = -1;
        acc_c = '{-100, -100};
        rsp_c = '{100, 100};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h11112222;
        for (int t = 0; t < 14; t++) begin
            if (n_acc == 1) begin
                cmd_we   = 1'b0;
                cmd_addr = 32'h60;
            end else if (n_acc >= 2) begin
                cmd_valid = 1'b0;
            end
            if (axi.awvalid_o && axi.arvalid_o) overlap = 1;
            if (axi.awvalid_o && axi.awaddr_o !== 32'h50) addr_ok = 0;
            if (axi.arvalid_o && axi.araddr_o !== 32'h60) addr_ok = 0;
            if (axi.arvalid_o && ar_first < 0) ar_first = cyc;
            if (rsp_valid) begin
                if (n_rsp < 2) rsp_c[n_rsp] = cyc;
                n_rsp++;
            end
            if (cmd_valid && cmd_ready) begin
                if (n_acc < 2) acc_c[n_acc] = cyc;
                n_acc++;
            end
            axi.awready_i = 1'b1;
            axi.wready_i  = 1'b1;
            axi.arready_i = 1'b1;
            axi.bresp_i   = 2'b00;
            axi.bvalid_i  = axi.bready_o;
            axi.rresp_i   = 2'b00;
            axi.rdata_i   = 32'h0BADF00D;
            axi.rvalid_i  = axi.rready_o;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        slave_idle();
        check("b2b_rsp_pulses", n_rsp, 2);
        check("b2b_accept_in_rsp_cycle", acc_c[1], rsp_c[0]);
        check("b2b_no_overlap", overlap, 1'b0);
        check("b2b_ar_after_rsp", ar_first, rsp_c[0] + 1);
        check("b2b_read_latency", rsp_c[1] - acc_c[1] + 1, 4);
        check("b2b_addr_stable", addr_ok, 1'b1);
        check("b2b_rdata", rsp_rdata, 32'h0BADF00D);

        // Reset while waiting for the write response.
        acc_flag = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h77777777;
        axi.awready_i = 1'b1;
        axi.wready_i  = 1'b1;
        for (int t = 0; t < 20 && !axi.bready_o; t++) begin
            if (acc_flag) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) acc_flag = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("mid_rst_in_wresp", axi.bready_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_handshakes", {axi.awvalid_o, axi.wvalid_o, axi.bready_o, axi.arvalid_o,
                                     axi.rready_o, rsp_valid, cmd_ready}, 7'b0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        axi.bvalid_i = 1'b1;
        saw_rsp = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
        end
        check("mid_rst_no_rsp", saw_rsp, 1'b0);
        check("mid_rst_ready_after", cmd_ready, 1'b1);
        slave_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
